// File: rtl/toy_pipe_kernel.sv
// rtl/toy_pipe_kernel.sv - pipelined lane-arithmetic kernel with avail/ready backpressure
// Each beat is split into lanes, one op applied per beat, then carried through a compacting register pipe.
module toy_pipe_kernel #(
  parameter int C_DATA_WIDTH = 512,
  parameter int LANE_WIDTH   = 32,
  parameter int PIPE_STAGES  = 2,
  parameter int INCREMENT    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    in_ready,
  input  logic                    in_avail,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  input  logic                    out_ready,
  output logic                    out_avail,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic [31:0]             beat_count
);

  localparam int NUM_LANES = C_DATA_WIDTH / LANE_WIDTH;
  localparam int LAST      = PIPE_STAGES - 1;
  localparam logic [LANE_WIDTH-1:0] INC_L = LANE_WIDTH'(INCREMENT);

  if ((C_DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
    $error("toy_pipe_kernel: C_DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("toy_pipe_kernel: PIPE_STAGES must be at least 1");
  end
  if (LANE_WIDTH != 8 && LANE_WIDTH != 16 && LANE_WIDTH != 32 && LANE_WIDTH != 64) begin : g_bad_lane
    $error("toy_pipe_kernel: LANE_WIDTH must be 8, 16, 32 or 64");
  end

  logic [C_DATA_WIDTH-1:0] op_result;
  logic [PIPE_STAGES-1:0]  valid_q, valid_d, adv;
  logic [C_DATA_WIDTH-1:0] data_q [PIPE_STAGES];
  logic [C_DATA_WIDTH-1:0] data_d [PIPE_STAGES];
  logic [31:0]             count_q, count_d;
  logic                    in_xfer, out_xfer;

  always_comb begin
    op_result = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (in_op)
        2'd0:    op_result[i*LANE_WIDTH +: LANE_WIDTH] = in_data[i*LANE_WIDTH +: LANE_WIDTH] + INC_L;
        2'd1:    op_result[i*LANE_WIDTH +: LANE_WIDTH] = in_data[i*LANE_WIDTH +: LANE_WIDTH] - INC_L;
        2'd2:    op_result[i*LANE_WIDTH +: LANE_WIDTH] = in_data[i*LANE_WIDTH +: LANE_WIDTH];
        default: op_result[i*LANE_WIDTH +: LANE_WIDTH] = ~in_data[i*LANE_WIDTH +: LANE_WIDTH];
      endcase
    end
  end

  // Advance ripples back from the output so a stalled tail lets earlier stages close gaps.
  always_comb begin
    adv       = '0;
    adv[LAST] = valid_q[LAST] & out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] & (~valid_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~reset & (~valid_q[0] | adv[0]);
  assign in_xfer  = in_avail & in_ready;
  assign out_xfer = adv[LAST];

  always_comb begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      valid_d[k] = valid_q[k] & ~adv[k];
      data_d[k]  = data_q[k];
    end
    if (in_xfer) begin
      valid_d[0] = 1'b1;
      data_d[0]  = op_result;
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (adv[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1];
      end
    end
    count_d = count_q + 32'(out_xfer);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_avail  = valid_q[LAST];
  assign out_data   = data_q[LAST];
  assign beat_count = count_q;

endmodule

// File: tb/tb_toy_pipe_kernel.sv
// tb/tb_toy_pipe_kernel.sv - self-checking bench for toy_pipe_kernel against a queue-based reference
module tb_toy_pipe_kernel;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_ready, in_avail, out_ready, out_avail;
  logic [511:0] in_data, out_data;
  logic [1:0]   in_op;
  logic [31:0]  beat_count;

  logic         v_in_ready, v_in_avail, v_out_ready, v_out_avail;
  logic [63:0]  v_in_data, v_out_data;
  logic [1:0]   v_in_op;
  logic [31:0]  v_beat_count;

  always #5 clk = ~clk;

  toy_pipe_kernel #(.C_DATA_WIDTH(512), .LANE_WIDTH(32), .PIPE_STAGES(2), .INCREMENT(1)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_avail(in_avail), .in_data(in_data),
    .in_op(in_op), .out_ready(out_ready), .out_avail(out_avail), .out_data(out_data),
    .beat_count(beat_count)
  );

  toy_pipe_kernel #(.C_DATA_WIDTH(64), .LANE_WIDTH(8), .PIPE_STAGES(4), .INCREMENT(1)) dut_v (
    .clk(clk), .reset(reset), .in_ready(v_in_ready), .in_avail(v_in_avail), .in_data(v_in_data),
    .in_op(v_in_op), .out_ready(v_out_ready), .out_avail(v_out_avail), .out_data(v_out_data),
    .beat_count(v_beat_count)
  );

  typedef struct {
    logic [511:0] data;
    int           acc;
  } beat_t;

  beat_t       q[$];
  int          cyc = 0;
  int          last_dep = -100;
  int unsigned exp_count = 0;
  int          checks = 0;
  int          failures = 0;
  logic        obs_in_ready, obs_out_avail, step_in_x, step_out_x;
  logic [511:0] obs_out_data;
  logic [31:0] obs_count;

  function automatic logic [511:0] ref_beat(input logic [511:0] d, input logic [1:0] op);
    logic [511:0] r;
    longint x;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = longint'(d[i*32 +: 32]);
      case (op)
        2'd0: x = x + 1;
        2'd1: x = x - 1;
        2'd2: x = x;
        default: x = 64'hFFFF_FFFF - x;
      endcase
      r[i*32 +: 32] = x[31:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] ref8(input logic [63:0] d, input logic [1:0] op);
    logic [63:0] r;
    int x;
    for (int i = 0; i < 8; i++) begin
      x = int'(d[i*8 +: 8]);
      case (op)
        2'd0: x = x + 1;
        2'd1: x = x - 1;
        2'd2: x = x;
        default: x = 255 - x;
      endcase
      r[i*8 +: 8] = x[7:0];
    end
    return r;
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic av, input logic [511:0] d, input logic [1:0] op, input logic ordy);
    logic exp_ir, exp_oa;
    int   rdy;
    @(negedge clk);
    in_avail  = av;
    in_data   = d;
    in_op     = op;
    out_ready = ordy;
    #1;
    exp_oa = 1'b0;
    if (q.size() > 0) begin
      rdy = q[0].acc + S;
      if (last_dep + 1 > rdy) rdy = last_dep + 1;
      exp_oa = (cyc >= rdy);
    end
    exp_ir = (q.size() < S) || ordy;
    check("in_ready", in_ready, exp_ir);
    check("out_avail", out_avail, exp_oa);
    if (exp_oa) check("out_data", out_data, q[0].data);
    check("beat_count", beat_count, exp_count);
    obs_in_ready  = in_ready;
    obs_out_avail = out_avail;
    obs_out_data  = out_data;
    obs_count     = beat_count;
    step_out_x = exp_oa && ordy;
    step_in_x  = av && exp_ir;
    if (step_out_x) begin
      void'(q.pop_front());
      last_dep = cyc;
      exp_count++;
    end
    if (step_in_x) q.push_back('{data: ref_beat(d, op), acc: cyc});
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_avail  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready_during_reset", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_avail = 1'b0;
    q.delete();
    last_dep  = -100;
    exp_count = 0;
    cyc++;
    check("post_reset_out_avail", out_avail, 1'b0);
    check("post_reset_out_data", out_data, 512'd0);
    check("post_reset_beat_count", beat_count, 32'd0);
  endtask

  initial begin
    int n_out, n_acc, base;
    logic [511:0] d;
    reset = 1'b1; in_avail = 1'b0; in_data = '0; in_op = 2'd0; out_ready = 1'b0;
    v_in_avail = 1'b0; v_in_data = '0; v_in_op = 2'd0; v_out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // 1: single add beat, latency 2
    do_reset();
    step(1'b1, {16{32'h0000_0005}}, 2'd0, 1'b1);
    check("t1_accepted", step_in_x, 1'b1);
    step(1'b0, '0, 2'd0, 1'b1);
    check("t1_not_early", obs_out_avail, 1'b0);
    step(1'b0, '0, 2'd0, 1'b1);
    check("t1_avail", obs_out_avail, 1'b1);
    check("t1_data", obs_out_data, {16{32'h0000_0006}});
    step(1'b0, '0, 2'd0, 1'b1);
    check("t1_count", obs_count, 32'd1);

    // 2: per-lane wrap without carry into neighbours
    step(1'b1, {8{32'hFFFF_FFFF, 32'h0000_0007}}, 2'd0, 1'b1);
    step(1'b1, {8{32'h0000_0000, 32'h0000_0007}}, 2'd1, 1'b1);
    step(1'b0, '0, 2'd0, 1'b1);
    check("t2_add_wrap", obs_out_data, {8{32'h0000_0000, 32'h0000_0008}});
    step(1'b0, '0, 2'd0, 1'b1);
    check("t2_sub_wrap", obs_out_data, {8{32'hFFFF_FFFF, 32'h0000_0006}});
    step(1'b0, '0, 2'd0, 1'b1);

    // 3: 100-beat stream at full rate
    base = int'(exp_count);
    n_out = 0; n_acc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, {16{i[31:0]}}, 2'($urandom_range(3)), 1'b1);
      if (step_in_x) n_acc++;
      if (step_out_x) n_out++;
    end
    for (int i = 0; i < S; i++) begin
      step(1'b0, '0, 2'd0, 1'b1);
      if (step_out_x) n_out++;
    end
    check("t3_accepted", n_acc, 100);
    check("t3_delivered", n_out, 100);
    step(1'b0, '0, 2'd0, 1'b1);
    check("t3_count", obs_count, 32'(base + 100));

    // 4: stall fills the pipe, release drains in order
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, {16{32'hA0 + n_acc[31:0]}}, 2'd2, 1'b0);
      if (step_in_x) n_acc++;
    end
    check("t4_accepted_stalled", n_acc, 2);
    check("t4_in_ready_low", obs_in_ready, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0);
    step(1'b0, '0, 2'd0, 1'b0);
    for (int i = 0; i < 6 && n_acc < 3; i++) begin
      step(1'b1, {16{32'hA0 + n_acc[31:0]}}, 2'd2, 1'b1);
      if (step_in_x) n_acc++;
    end
    check("t4_third_accepted", n_acc, 3);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 2'd0, 1'b1);
    check("t4_count", obs_count, 32'd3);

    // 5: random traffic on both sides
    n_out = 0;
    for (int i = 0; i < 60000 && n_out < 10000; i++) begin
      d = rand_beat();
      step(1'($urandom_range(1)), d, 2'($urandom_range(3)), 1'($urandom_range(1)));
      if (step_out_x) n_out++;
    end
    check("t5_beats_out", n_out, 10000);
    step(1'b0, '0, 2'd0, 1'b0);
    check("t5_count", obs_count, exp_count);

    // 6: reset with beats in flight
    step(1'b1, rand_beat(), 2'd0, 1'b0);
    step(1'b1, rand_beat(), 2'd3, 1'b0);
    do_reset();
    n_out = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 2'd0, 1'b1);
      if (obs_out_avail) n_out++;
    end
    check("t6_no_stale", n_out, 0);

    // 8-bit lanes, 4 stages
    @(negedge clk);
    v_in_avail = 1'b1; v_in_data = 64'hFFFF_FFFF_FFFF_FFFF; v_in_op = 2'd3; v_out_ready = 1'b1;
    #1;
    check("v_in_ready", v_in_ready, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      v_in_avail = (t == 1);
      v_in_data  = 64'h7F01_FF00_80FE_0A7F;
      v_in_op    = 2'd0;
      #1;
      if (t < 4) check("v_not_early", v_out_avail, 1'b0);
    end
    check("v_avail", v_out_avail, 1'b1);
    check("v_invert", v_out_data, ref8(64'hFFFF_FFFF_FFFF_FFFF, 2'd3));
    @(negedge clk);
    v_in_avail = 1'b0;
    #1;
    check("v_add_wrap", v_out_data, ref8(64'h7F01_FF00_80FE_0A7F, 2'd0));
    @(negedge clk);
    #1;
    check("v_count", v_beat_count, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
